stopwatch_gen: RTL

- Parametrised successor to the four-digit stopwatch. It provides N BCD digits, each with a modulus of 10 or 6, and counts up or down.
- Adds a lap freeze, manual digit entry with an explicit cursor, and a countdown-expiry pulse.
- Sits at the board top level: takes raw active-low push buttons and drives N active-low seven-segment displays.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_gen_bcd_to_hex.sv | 26 ++
 rtl/stopwatch_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the parametrised BCD stopwatch.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SET  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Modulus of digit i: 6 where the mask bit is set, 10 otherwise.
  function automatic logic [3:0] digit_base(input logic [7:0] mask, input logic [2:0] i);
    return mask[i] ? 4'd6 : 4'd10;
  endfunction

endpackage

// File: rtl/stopwatch_gen_bcd_to_hex.sv
// BCD digit to active-low seven-segment decoder; codes 10..15 blank the digit.
module bcd_to_hex
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] hex_o
);

  always_comb begin
    hex_o = SEG_OFF;
    unique case (bcd_i)
      4'd0:    hex_o = SEG_0;
      4'd1:    hex_o = SEG_1;
      4'd2:    hex_o = SEG_2;
      4'd3:    hex_o = SEG_3;
      4'd4:    hex_o = SEG_4;
      4'd5:    hex_o = SEG_5;
      4'd6:    hex_o = SEG_6;
      4'd7:    hex_o = SEG_7;
      4'd8:    hex_o = SEG_8;
      4'd9:    hex_o = SEG_9;
      default: hex_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/stopwatch_gen.sv
// N-digit up/down BCD stopwatch with lap freeze, cursor-based digit entry and
// countdown-expiry pulse; raw active-low buttons in, active-low segments out.
module stopwatch_gen
  import stopwatch_pkg::*;
#(
  parameter int                CLK_FREQ_HZ = 100_000_000,
  parameter int                TICK_HZ     = 100,
  parameter int                DIGITS      = 4,
  parameter logic [DIGITS-1:0] MOD6_MASK   = 'b1000
) (
  input  logic                        clk100_i,
  input  logic                        rst_i,
  input  logic                        start_stop_i,
  input  logic                        set_i,
  input  logic                        change_i,
  input  logic                        lap_i,
  input  logic                        mode_i,
  output logic [7*DIGITS-1:0]         hex_o,
  output logic [4*DIGITS-1:0]         bcd_o,
  output logic                        running_o,
  output logic                        setting_o,
  output logic [$clog2(DIGITS)-1:0]   cursor_o,
  output logic                        lap_o,
  output logic                        done_o
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DIGITS);
  localparam logic [7:0] MASK8 = 8'(MOD6_MASK);

  logic [3:0] btn_n;
  logic [3:0] ev;
  logic       ev_start, ev_set, ev_change, ev_lap;

  assign btn_n = {lap_i, change_i, set_i, start_stop_i};

  // Per-button 2-flop synchroniser plus a third flop for falling-edge detect.
  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic s1_q, s2_q, s3_q;
    always_ff @(posedge clk100_i) begin
      if (rst_i) begin
        s1_q <= 1'b1;
        s2_q <= 1'b1;
        s3_q <= 1'b1;
      end else begin
        s1_q <= btn_n[b];
        s2_q <= s1_q;
        s3_q <= s2_q;
      end
    end
    assign ev[b] = s3_q & ~s2_q;
  end

  assign ev_start  = ev[0];
  assign ev_set    = ev[1];
  assign ev_change = ev[2];
  assign ev_lap    = ev[3];

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shown_q, shown_d;
  logic [CW-1:0]       cursor_q, cursor_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                lap_q, lap_d;
  logic                done_q, done_d;
  logic                dir_q, dir_d;

  logic [4*DIGITS-1:0] inc_v, dec_v;
  logic [3:0]          cur_dig, cur_base, chg_dig;
  logic                tick;

  // Ripple-carry increment and ripple-borrow decrement of the whole count.
  always_comb begin
    logic carry;
    logic borrow;
    inc_v  = cnt_q;
    dec_v  = cnt_q;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] >= digit_base(MASK8, 3'(i)) - 4'd1) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_q[4*i +: 4] == 4'd0) begin
          dec_v[4*i +: 4] = digit_base(MASK8, 3'(i)) - 4'd1;
        end else begin
          dec_v[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cur_dig  = cnt_q[4*cursor_q +: 4];
    cur_base = digit_base(MASK8, 3'(cursor_q));
    chg_dig  = (cur_dig >= cur_base - 4'd1) ? 4'd0 : cur_dig + 4'd1;
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    presc_d  = presc_q;
    lap_d    = lap_q;
    done_d   = 1'b0;
    dir_d    = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ev_start) begin
          dir_d   = mode_i;
          presc_d = '0;
          // A countdown from zero has nothing to do; stay put silently.
          if (!(mode_i && (cnt_q == '0))) state_d = ST_RUN;
        end else if (ev_set) begin
          state_d  = ST_SET;
          cursor_d = CW'(DIGITS - 1);
        end
      end
      ST_RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          cnt_d = dir_q ? dec_v : inc_v;
          if (dir_q && (dec_v == '0)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            lap_d   = 1'b0;
          end
        end
        if (ev_start) begin
          state_d = ST_IDLE;
          lap_d   = 1'b0;
        end else if (ev_lap && (state_d == ST_RUN)) begin
          lap_d = ~lap_q;
        end
      end
      ST_SET: begin
        if (ev_set) begin
          if (cursor_q == '0) state_d = ST_IDLE;
          else                cursor_d = cursor_q - 1'b1;
        end else if (ev_change) begin
          cnt_d[4*cursor_q +: 4] = chg_dig;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    shown_d = lap_d ? shown_q : cnt_d;
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shown_q  <= '0;
      cursor_q <= '0;
      presc_q  <= '0;
      lap_q    <= 1'b0;
      done_q   <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shown_q  <= shown_d;
      cursor_q <= cursor_d;
      presc_q  <= presc_d;
      lap_q    <= lap_d;
      done_q   <= done_d;
      dir_q    <= dir_d;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    bcd_to_hex u_dec (
      .bcd_i (shown_q[4*i +: 4]),
      .hex_o (hex_o[7*i +: 7])
    );
  end

  assign bcd_o     = shown_q;
  assign running_o = (state_q == ST_RUN);
  assign setting_o = (state_q == ST_SET);
  assign cursor_o  = cursor_q;
  assign lap_o     = lap_q;
  assign done_o    = done_q;

endmodule
